// File: rtl/fetch_queue_if.sv
// Bundles the instruction-memory and decode-side signals of the fetch front end.
// The fetch_queue drives through the master modport; the environment uses slave.
interface fetch_queue_if #(
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          stall;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_next;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next, count,
    input  imem_data, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next, count,
    output imem_data, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues synchronous-read fetches and
// buffers returned instructions in a DEPTH-entry queue for decode.
module fetch_queue #(
  parameter int            AW       = 32,
  parameter int            IW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] STEP     = AW'(1)
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [IW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];

  logic          valid;
  logic          deq;
  logic          issue;
  logic [CW:0]   occ;

  always_comb begin
    valid = reset && !bus.redirect && (count != '0);
    deq   = valid && !bus.stall;
    // Occupancy after this edge if the in-flight word lands; never underflows
    // because deq implies count >= 1.
    occ   = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(deq);
    issue = reset && (bus.redirect || (occ < DEPTH_W));
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = (reset && bus.redirect) ? bus.redirect_pc : fetch_pc;
  assign bus.out_valid   = valid;
  assign bus.out_instr   = q_instr[head];
  assign bus.out_pc      = q_pc[head];
  assign bus.out_pc_next = q_pc[head] + STEP;
  assign bus.count       = count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (bus.redirect) begin
      head        <= tail;
      count       <= '0;
      inflight    <= 1'b1;
      inflight_pc <= bus.redirect_pc;
      fetch_pc    <= bus.redirect_pc + STEP;
    end else begin
      if (inflight) tail <= tail + PW'(1);
      if (deq)      head <= head + PW'(1);
      count    <= occ[CW-1:0];
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + STEP;
      end
    end
  end

  // Queue storage needs no reset; entries are only read once counted valid.
  always_ff @(posedge clock) begin
    if (reset && !bus.redirect && inflight) begin
      q_instr[tail] <= bus.imem_data;
      q_pc[tail]    <= inflight_pc;
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the 5-stage pipeline. It owns the program counter and issues requests to a synchronous-read instruction memory. It buffers returned instructions, each tagged with its PC and PC+STEP, in a DEPTH-entry queue and hands them to decode with a stall handshake. Branch/jump redirects flush the queue and any in-flight fetch.

## Interface
- AW, 32: PC / imem address width.
- IW, 32: instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC loaded on reset (AW bits).
- STEP, 1: PC increment per instruction (word addressing).

- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch issued this cycle.
- imem_addr  out  AW  address of the fetch; valid when imem_req=1.
- imem_data  in  IW  instruction for the address issued in the previous cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  AW  redirect target.
- stall  in  1  decode cannot accept this cycle.
- out_valid  out  1  head entry valid for decode.
- out_instr  out  IW  head instruction.
- out_pc  out  AW  PC of head instruction.
- out_pc_next  out  AW  out_pc+STEP, modulo 2^AW.
- count  out  clog2(DEPTH+1)  queue occupancy.

## Operation
- State:
  - fetch_pc (AW).
  - inflight bit plus inflight_pc (AW) for the request issued last cycle.
  - circular queue of DEPTH entries {instr, pc}, with head/tail pointers and count.
- Dequeue: deq = out_valid & ~stall. On deq, head advances and count decrements.
- Issue rule, normal cycle: issue when count + inflight − deq < DEPTH.
  - On issue: imem_req=1, imem_addr=fetch_pc, fetch_pc ← fetch_pc+STEP, inflight ← 1, inflight_pc ← fetch_pc.
  - Otherwise: imem_req=0, imem_addr=fetch_pc, inflight ← 0.
- Return: when inflight=1 and no redirect this cycle, {imem_data, inflight_pc} is written at tail; tail and count advance.
- The issue rule guarantees no enqueue ever lands on a full queue. Overflow is a design error; the bench asserts it never occurs.
- Redirect has priority over stall, dequeue, enqueue and the normal issue rule. In a redirect cycle:
  - Queue is emptied: head=tail, count=0.
  - The in-flight return this cycle is discarded.
  - out_valid is forced 0, so no dequeue happens.
  - imem_req=1, imem_addr=redirect_pc, inflight ← 1, inflight_pc ← redirect_pc, fetch_pc ← redirect_pc+STEP.
- Back-to-back redirects: each one supersedes the previous; only the last target's stream appears.
- All PC arithmetic is modulo 2^AW. fetch_pc = 2^AW−STEP wraps to 0 with no flag.
- Reset, when reset=0 at the edge:
  - fetch_pc=RESET_PC, inflight=0, head=tail=0, count=0.
  - During reset cycles: imem_req=0, out_valid=0.
  - Reset overrides redirect and discards any in-flight data.

## Timing
- Outputs after reset: imem_req=0, imem_addr=RESET_PC, out_valid=0, count=0. out_instr, out_pc and out_pc_next are don't-care.
- Cycle R is the first cycle with reset=1: imem_req=1, imem_addr=RESET_PC.
- R+1: data returns and is enqueued at the edge ending R+1.
- R+2: out_valid=1, out_pc=RESET_PC. Issue-to-output latency is 2 cycles.
- Redirect in cycle X: target appears at out_valid in X+2. out_valid=0 in X and X+1.
- Steady state with stall=0: one instruction per cycle, count settles at 1.
- With stall held: queue fills to DEPTH, then imem_req=0. When stall drops, the first deq and a new issue occur in the same cycle.
- out_valid, out_instr, out_pc and out_pc_next are registered-state driven; no combinational path from imem_data. Exception: out_valid is forced low by redirect.

## Test plan
- Reset release, stall=0, imem returns 0x1000+addr:
  - out_pc=0,1,2,… from cycle R+2, one per cycle.
  - out_instr=0x1000+out_pc; out_pc_next=out_pc+1; count=1.
- stall=1 from R+2, DEPTH=4:
  - count reaches 4; imem_req=0 thereafter.
  - On stall release, entries 0..3 emerge in order, then 4,5,… with no gap and no duplicate.
- Redirect to 0x40 while count=3 and a fetch is in flight:
  - out_valid=0 for 2 cycles.
  - Next outputs are pc 0x40,0x41,…; no pre-redirect instruction ever appears.
- redirect=1 with stall=1 in the same cycle:
  - Queue flushed, count=0; the target still appears 2 cycles later.
- Reset asserted mid-stream with a fetch in flight:
  - Next cycle count=0, out_valid=0, imem_req=0.
  - After release, fetch restarts at RESET_PC.
- AW=8, redirect to 0xFE: output sequence 0xFE, 0xFF, 0x00, 0x01.
